// File: rtl/my_rst_pkg.sv
// Shared state encoding and default timing for the staged reset sequencer.
package my_rst_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK,
    HOLD,
    RELEASE,
    DONE,
    RUN
  } rst_state_e;

  localparam int RST_NUM_STAGES  = 3;
  localparam int RST_HOLD_CYCLES = 16;
  localparam int RST_STAGE_GAP   = 8;
  localparam int RST_CNT_W       = 8;

endpackage

// File: rtl/my_sync2.sv
// Two-flop synchronizer for a single asynchronous level; clears to 0 on rst.
module my_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/my_rst_sequencer.sv
// Staged reset release: wait for lock, hold, then release stage resets in
// ascending order with a fixed gap between stages.
//
//   state     | meaning
//   WAIT_LOCK | all resets asserted, clock gated, waiting for synchronized lock
//   HOLD      | locked, clock enabled, counting the hold interval
//   RELEASE   | releasing remaining stages one per gap interval
//   DONE      | all stages released, completion flagged next edge
//   RUN       | sequence complete, idle until restart
module my_rst_sequencer
  import my_rst_pkg::*;
#(
  parameter int NUM_STAGES  = RST_NUM_STAGES,
  parameter int HOLD_CYCLES = RST_HOLD_CYCLES,
  parameter int STAGE_GAP   = RST_STAGE_GAP,
  parameter int CNT_W       = RST_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lock_i,
  input  logic                  sw_rst_req,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  clk_en,
  output logic                  rst_done,
  output logic                  busy
);

  localparam logic [NUM_STAGES-1:0] STAGE_ONE = NUM_STAGES'(1);
  localparam logic [NUM_STAGES-1:0] STAGE_ALL = '1;
  localparam logic [CNT_W-1:0]      HOLD_CMP  = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0]      GAP_CMP   = CNT_W'(STAGE_GAP);
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);

  rst_state_e            state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [NUM_STAGES-1:0] stage_q;
  logic                  clk_en_q;
  logic                  done_q;
  logic                  busy_q;

  logic                  lock_s;
  logic                  lock_lost;
  logic                  restart;
  logic [NUM_STAGES-1:0] stage_d;

  my_sync2 u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d_i (lock_i),
    .q_o (lock_s)
  );

  assign lock_lost = !lock_s && (state_q != WAIT_LOCK);
  assign restart   = sw_rst_req || lock_lost;
  assign stage_d   = (stage_q << 1) | STAGE_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= WAIT_LOCK;
      cnt_q    <= '0;
      stage_q  <= '0;
      clk_en_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b1;
    end else if (restart || (state_q == WAIT_LOCK)) begin
      // Lock acquisition and restart share one path: with lock present the
      // hold count starts at 1 on this edge, otherwise we park in WAIT_LOCK.
      stage_q  <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b1;
      clk_en_q <= lock_s;
      cnt_q    <= lock_s ? CNT_ONE : '0;
      state_q  <= lock_s ? HOLD : WAIT_LOCK;
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_q == HOLD_CMP) begin
            stage_q <= STAGE_ONE;
            cnt_q   <= CNT_ONE;
            state_q <= (NUM_STAGES == 1) ? DONE : RELEASE;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        RELEASE: begin
          if (cnt_q == GAP_CMP) begin
            stage_q <= stage_d;
            cnt_q   <= CNT_ONE;
            if (stage_d == STAGE_ALL) begin
              state_q <= DONE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        DONE: begin
          state_q <= RUN;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
        RUN: begin
          state_q <= RUN;
        end
        default: begin
          state_q <= WAIT_LOCK;
        end
      endcase
    end
  end

  assign stage_rst_n = stage_q;
  assign clk_en      = clk_en_q;
  assign rst_done    = done_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_my_rst_sequencer.sv
// Bench for my_rst_sequencer: default and minimal (1/1/1) instances share stimulus
// and are checked every cycle against an elapsed-time model of the release schedule.
module tb_my_rst_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       lock_i;
  logic       sw_rst_req;
  logic [2:0] a_stage;
  logic       a_clk_en, a_done, a_busy;
  logic [0:0] b_stage;
  logic       b_clk_en, b_done, b_busy;
  logic [9:0] obs;

  int tests  = 0;
  int fails  = 0;
  int edge_n = -1;

  // Model: lock pipeline plus the edge at which the current sequence started.
  bit l1, l2, act;
  int t0;

  my_rst_sequencer #(.NUM_STAGES(3), .HOLD_CYCLES(16), .STAGE_GAP(8), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .lock_i(lock_i), .sw_rst_req(sw_rst_req),
    .stage_rst_n(a_stage), .clk_en(a_clk_en), .rst_done(a_done), .busy(a_busy)
  );

  my_rst_sequencer #(.NUM_STAGES(1), .HOLD_CYCLES(1), .STAGE_GAP(1), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .lock_i(lock_i), .sw_rst_req(sw_rst_req),
    .stage_rst_n(b_stage), .clk_en(b_clk_en), .rst_done(b_done), .busy(b_busy)
  );

  assign obs = {a_stage, a_clk_en, a_done, a_busy, b_stage, b_clk_en, b_done, b_busy};

  always #5 clk = ~clk;

  function automatic logic [5:0] exp_vec(input int n, input int hold, input int gap);
    int e, k;
    logic d;
    logic [2:0] m;
    if (!act) return 6'b000001;
    e = edge_n - t0;
    k = 0;
    for (int j = 0; j < n; j++) if (e >= hold + j * gap) k++;
    d = (e >= hold + (n - 1) * gap + 1);
    m = 3'((1 << k) - 1);
    return {m, 1'b1, d, !d};
  endfunction

  function automatic logic [9:0] exp_all();
    logic [5:0] ea, eb;
    ea = exp_vec(3, 16, 8);
    eb = exp_vec(1, 1, 1);
    return {ea, eb[3:0]};
  endfunction

  task automatic model_reset();
    l1 = 1'b0; l2 = 1'b0; act = 1'b0; t0 = 0;
  endtask

  task automatic step();
    bit seen;
    @(posedge clk);
    edge_n++;
    if (rst) begin
      model_reset();
    end else begin
      seen = l2; l2 = l1; l1 = lock_i;
      if (!seen) act = 1'b0;
      else if (!act || sw_rst_req) begin
        act = 1'b1;
        t0  = edge_n;
      end
    end
    @(negedge clk);
  endtask

  task automatic apply_reset(input logic lk);
    rst = 1'b1; lock_i = lk; sw_rst_req = 1'b0;
    model_reset();
    step(); step();
    rst = 1'b0; edge_n = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; lock_i = 1'b0; sw_rst_req = 1'b0;
    model_reset();
    #1;
    tests++;
    if (obs !== 10'b000_0_0_1_0_0_0_1) begin
      fails++; $display("FAIL reset_values got %b want %b", obs, 10'b000_0_0_1_0_0_0_1);
    end
    lock_i = 1'b1;
    repeat (4) begin
      step(); tests++;
      if (obs !== exp_all()) begin
        fails++; $display("FAIL reset_held got %b want %b", obs, exp_all());
      end
    end
  endtask

  task automatic test_defaults();
    int got[7];
    int want[7] = '{2, 18, 26, 34, 35, 3, 4};
    for (int i = 0; i < 7; i++) got[i] = -1;
    apply_reset(1'b1);
    while (edge_n < 40) begin
      step(); tests++;
      if (obs !== exp_all()) begin
        fails++; $display("FAIL defaults_cycle edge %0d got %b want %b", edge_n, obs, exp_all());
      end
      if (a_clk_en && got[0] < 0)          got[0] = edge_n;
      if (a_stage == 3'b001 && got[1] < 0) got[1] = edge_n;
      if (a_stage == 3'b011 && got[2] < 0) got[2] = edge_n;
      if (a_stage == 3'b111 && got[3] < 0) got[3] = edge_n;
      if (a_done && got[4] < 0)            got[4] = edge_n;
      if (b_stage[0] && got[5] < 0)        got[5] = edge_n;
      if (b_done && got[6] < 0)            got[6] = edge_n;
    end
    for (int i = 0; i < 7; i++) begin
      tests++;
      if (got[i] != want[i]) begin
        fails++; $display("FAIL defaults_event[%0d] got edge %0d want edge %0d", i, got[i], want[i]);
      end
    end
  endtask

  task automatic test_late_lock_sw();
    int mq[$], dq[$], cq[$];
    int want_m[7] = '{68, 76, 84, 100, 116, 124, 132};
    int want_d[2] = '{85, 133};
    int got;
    logic [9:0] prev;
    apply_reset(1'b0);
    prev = obs;
    while (edge_n < 140) begin
      lock_i     = (edge_n + 1 >= 50);
      sw_rst_req = (edge_n + 1 == 100);
      step(); tests++;
      if (obs !== exp_all()) begin
        fails++; $display("FAIL late_lock_cycle edge %0d got %b want %b", edge_n, obs, exp_all());
      end
      if (a_stage != prev[9:7])   mq.push_back(edge_n);
      if (a_done && !prev[5])     dq.push_back(edge_n);
      if (a_clk_en != prev[6])    cq.push_back(edge_n);
      prev = obs;
    end
    sw_rst_req = 1'b0;
    for (int i = 0; i < 7; i++) begin
      got = (i < mq.size()) ? mq[i] : -1;
      tests++;
      if (got != want_m[i]) begin
        fails++; $display("FAIL late_lock_stage_change[%0d] got edge %0d want edge %0d", i, got, want_m[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      got = (i < dq.size()) ? dq[i] : -1;
      tests++;
      if (got != want_d[i]) begin
        fails++; $display("FAIL late_lock_done_rise[%0d] got edge %0d want edge %0d", i, got, want_d[i]);
      end
    end
    got = (cq.size() == 1) ? cq[0] : -1;
    tests++;
    if (got != 52) begin
      fails++; $display("FAIL late_lock_clk_en got edge %0d (changes %0d) want single rise at 52", got, cq.size());
    end
  endtask

  task automatic test_lock_loss();
    int mq[$], cq[$];
    int want_m[6] = '{18, 26, 27, 58, 66, 74};
    int want_c[3] = '{2, 27, 42};
    int got;
    logic [9:0] prev;
    apply_reset(1'b1);
    prev = obs;
    while (edge_n < 80) begin
      lock_i = (edge_n + 1 < 25) || (edge_n + 1 >= 40);
      step(); tests++;
      if (obs !== exp_all()) begin
        fails++; $display("FAIL lock_loss_cycle edge %0d got %b want %b", edge_n, obs, exp_all());
      end
      if (edge_n == 27) begin
        tests++;
        if (obs[9:4] !== 6'b000001) begin
          fails++; $display("FAIL lock_loss_edge27 got %b want 000001", obs[9:4]);
        end
      end
      if (a_stage != prev[9:7]) mq.push_back(edge_n);
      if (a_clk_en != prev[6])  cq.push_back(edge_n);
      prev = obs;
    end
    for (int i = 0; i < 6; i++) begin
      got = (i < mq.size()) ? mq[i] : -1;
      tests++;
      if (got != want_m[i]) begin
        fails++; $display("FAIL lock_loss_stage_change[%0d] got edge %0d want edge %0d", i, got, want_m[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      got = (i < cq.size()) ? cq[i] : -1;
      tests++;
      if (got != want_c[i]) begin
        fails++; $display("FAIL lock_loss_clk_en_change[%0d] got edge %0d want edge %0d", i, got, want_c[i]);
      end
    end
  endtask

  task automatic test_async_rst();
    apply_reset(1'b1);
    while (edge_n < 30) begin
      step(); tests++;
      if (obs !== exp_all()) begin
        fails++; $display("FAIL async_rst_cycle edge %0d got %b want %b", edge_n, obs, exp_all());
      end
    end
    tests++;
    if (a_stage !== 3'b011) begin
      fails++; $display("FAIL async_rst_precondition got %b want 011", a_stage);
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    tests++;
    if (obs !== 10'b000_0_0_1_0_0_0_1) begin
      fails++; $display("FAIL async_rst_immediate got %b want %b", obs, 10'b000_0_0_1_0_0_0_1);
    end
    step();
  endtask

  task automatic test_sw_held();
    apply_reset(1'b1);
    while (edge_n < 120) begin
      sw_rst_req = (edge_n + 1 >= 40) && (edge_n + 1 < 70);
      step(); tests++;
      if (obs !== exp_all()) begin
        fails++; $display("FAIL sw_held_cycle edge %0d got %b want %b", edge_n, obs, exp_all());
      end
      if (sw_rst_req) begin
        tests++;
        if (a_stage !== 3'b000 || b_stage !== 1'b0 || !a_clk_en) begin
          fails++; $display("FAIL sw_held_no_release edge %0d got a=%b b=%b ce=%b want a=000 b=0 ce=1",
                            edge_n, a_stage, b_stage, a_clk_en);
        end
      end
    end
    sw_rst_req = 1'b0;
  endtask

  task automatic test_random();
    int hold_left = 0;
    apply_reset(1'b1);
    repeat (3000) begin
      if ($urandom_range(0, 199) == 0) lock_i = ~lock_i;
      if (hold_left == 0 && $urandom_range(0, 59) == 0) hold_left = $urandom_range(1, 8);
      sw_rst_req = (hold_left > 0);
      if (hold_left > 0) hold_left--;
      step(); tests++;
      if (obs !== exp_all()) begin
        fails++; $display("FAIL random_cycle edge %0d got %b want %b", edge_n, obs, exp_all());
      end
    end
    sw_rst_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_late_lock_sw();
    test_lock_loss();
    test_async_rst();
    test_sw_held();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
